// File: rtl/nubus_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface nubus_mem_arbiter_if;
   logic        a_valid;
   logic [3:0]  a_write;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic        a_ready;
   logic        a_error;

   logic        b_valid;
   logic [3:0]  b_write;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic        b_ready;
   logic        b_error;
   logic        b_lock;

   logic        mem_valid;
   logic [3:0]  mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic        arb_owner;
   logic        arb_busy;

   modport slave (
      input  a_valid, a_write, a_addr, a_wdata,
      output a_rdata, a_ready, a_error,
      input  b_valid, b_write, b_addr, b_wdata, b_lock,
      output b_rdata, b_ready, b_error,
      output mem_valid, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output arb_owner, arb_busy
   );

   modport master (
      output a_valid, a_write, a_addr, a_wdata,
      input  a_rdata, a_ready, a_error,
      output b_valid, b_write, b_addr, b_wdata, b_lock,
      input  b_rdata, b_ready, b_error,
      input  mem_valid, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  arb_owner, arb_busy
   );
endinterface

// File: rtl/nubus_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NuBus slave (A) and a local agent (B).
// Optional port-B locked sequences are enabled with the macro NUBUS_ARB_LOCK_EN.
module nubus_mem_arbiter #(
   parameter int unsigned TIMEOUT_CLOCKS = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input logic                 nub_clkn,
   input logic                 nub_resetn,
   nubus_mem_arbiter_if.slave  bus
);
   localparam int unsigned      WD_W    = $clog2(TIMEOUT_CLOCKS + 1) + 1;
   localparam bit               WD_EN   = (TIMEOUT_CLOCKS != 0);
   localparam logic [WD_W-1:0]  WD_LAST = WD_EN ? WD_W'(TIMEOUT_CLOCKS - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RECOVER = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_owner_q, last_owner_d;
   logic              owner_q, owner_d;
   logic              busy_q, busy_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              mem_valid_q, mem_valid_d;
   logic [3:0]        mem_write_q, mem_write_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       a_rdata_q, a_rdata_d;
   logic              a_ready_q, a_ready_d;
   logic              a_error_q, a_error_d;
   logic [31:0]       b_rdata_q, b_rdata_d;
   logic              b_ready_q, b_ready_d;
   logic              b_error_q, b_error_d;
`ifdef NUBUS_ARB_LOCK_EN
   logic              lock_q, lock_d;
`endif

   logic              grant_any_s;
   logic              grant_b_s;
   logic              timeout_hit_s;
   logic              fin_err_s;
   logic [31:0]       fin_rdata_s;

   assign timeout_hit_s = WD_EN && (wd_q == WD_LAST);

   // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
   always_comb begin
      grant_any_s = 1'b0;
      grant_b_s   = 1'b0;
`ifdef NUBUS_ARB_LOCK_EN
      if (lock_q) begin
         grant_any_s = bus.b_valid;
         grant_b_s   = 1'b1;
      end else
`endif
      begin
         if (bus.a_valid && bus.b_valid) begin
            grant_any_s = 1'b1;
            grant_b_s   = ~last_owner_q;
         end else if (bus.a_valid) begin
            grant_any_s = 1'b1;
            grant_b_s   = 1'b0;
         end else if (bus.b_valid) begin
            grant_any_s = 1'b1;
            grant_b_s   = 1'b1;
         end else begin
            grant_any_s = 1'b0;
            grant_b_s   = 1'b0;
         end
      end
   end

   // Next-state and registered-output computation for the IDLE/BUSY/RECOVER sequence.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      wd_d         = wd_q;
      mem_valid_d  = mem_valid_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      a_rdata_d    = a_rdata_q;
      a_ready_d    = 1'b0;
      a_error_d    = 1'b0;
      b_rdata_d    = b_rdata_q;
      b_ready_d    = 1'b0;
      b_error_d    = 1'b0;
`ifdef NUBUS_ARB_LOCK_EN
      lock_d       = lock_q;
`endif
      fin_err_s    = 1'b0;
      fin_rdata_s  = bus.mem_rdata;

      case (state_q)
         ST_IDLE: begin
            if (grant_any_s) begin
               owner_d     = grant_b_s;
               mem_valid_d = 1'b1;
               mem_write_d = grant_b_s ? bus.b_write : bus.a_write;
               mem_addr_d  = grant_b_s ? bus.b_addr  : bus.a_addr;
               mem_wdata_d = grant_b_s ? bus.b_wdata : bus.a_wdata;
               wd_d        = '0;
               state_d     = ST_BUSY;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // mem_ready on the timeout edge still counts as a normal completion.
            if (bus.mem_ready || timeout_hit_s) begin
               fin_err_s   = ~bus.mem_ready;
               fin_rdata_s = bus.mem_ready ? bus.mem_rdata : TIMEOUT_RDATA;
               if (owner_q) begin
                  b_rdata_d = fin_rdata_s;
                  b_ready_d = 1'b1;
                  b_error_d = fin_err_s;
`ifdef NUBUS_ARB_LOCK_EN
                  lock_d    = bus.b_lock & ~fin_err_s;
`endif
               end else begin
                  a_rdata_d = fin_rdata_s;
                  a_ready_d = 1'b1;
                  a_error_d = fin_err_s;
               end
               mem_valid_d  = 1'b0;
               last_owner_d = owner_q;
               wd_d         = '0;
               state_d      = ST_RECOVER;
            end else begin
               wd_d         = WD_EN ? (wd_q + WD_W'(1)) : wd_q;
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d == ST_BUSY);
   end

   // State and output registers; the memory shares the falling edge of nub_clkn.
   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state_q      <= ST_IDLE;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         busy_q       <= 1'b0;
         wd_q         <= '0;
         mem_valid_q  <= 1'b0;
         mem_write_q  <= 4'h0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         a_rdata_q    <= 32'h0;
         a_ready_q    <= 1'b0;
         a_error_q    <= 1'b0;
         b_rdata_q    <= 32'h0;
         b_ready_q    <= 1'b0;
         b_error_q    <= 1'b0;
`ifdef NUBUS_ARB_LOCK_EN
         lock_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         busy_q       <= busy_d;
         wd_q         <= wd_d;
         mem_valid_q  <= mem_valid_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         a_rdata_q    <= a_rdata_d;
         a_ready_q    <= a_ready_d;
         a_error_q    <= a_error_d;
         b_rdata_q    <= b_rdata_d;
         b_ready_q    <= b_ready_d;
         b_error_q    <= b_error_d;
`ifdef NUBUS_ARB_LOCK_EN
         lock_q       <= lock_d;
`endif
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.a_ready   = a_ready_q;
   assign bus.a_error   = a_error_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.b_ready   = b_ready_q;
   assign bus.b_error   = b_error_q;
   assign bus.arb_owner = owner_q;
   assign bus.arb_busy  = busy_q;
endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Randomized bench for nubus_mem_arbiter; a transaction-level schedule model predicts
// grants, completions and busy intervals. Honours NUBUS_ARB_LOCK_EN when defined.
module tb_nubus_mem_arbiter;
   localparam int TB_TO = 8;
   localparam int LOG_N = 16384;
   localparam int INF   = 1 << 30;
`ifdef NUBUS_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          lock;
      int          gap;
   } req_t;

   typedef struct {
      int          edge_n;
      bit          port;
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] wd;
   } gnt_t;

   typedef struct {
      int          edge_n;
      bit          port;
      logic [31:0] rdata;
      bit          err;
   } cpl_t;

   logic nub_clkn;
   logic nub_resetn;
   nubus_mem_arbiter_if ifc ();

   nubus_mem_arbiter #(.TIMEOUT_CLOCKS(TB_TO), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
      .nub_clkn   (nub_clkn),
      .nub_resetn (nub_resetn),
      .bus        (ifc)
   );

   int          n_checks = 0;
   int          n_errs   = 0;
   int          cyc      = 0;
   int          unstable = 0;
   req_t        req_a[$], req_b[$];
   int          iss_a[$], iss_b[$];
   gnt_t        obs_g[$];
   cpl_t        obs_c[$];
   bit          busy_log [LOG_N];
   bit          valid_log[LOG_N];
   bit          exp_busy [LOG_N];
   logic [31:0] mem_model[1024];
   logic [31:0] ref_mem  [1024];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int wait_of(input logic [31:0] a);
      logic [1:0] w;
      w = a[5:4] ^ 2'b01;
      return int'(w);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   initial begin
      nub_clkn = 1'b1;
      forever #5 nub_clkn = ~nub_clkn;
   end

   initial begin
      forever begin
         @(negedge nub_clkn);
         cyc++;
      end
   end

   // Memory: acknowledges after wait_of(addr) extra clocks; D-region addresses never answer.
   initial begin
      int wcnt;
      wcnt          = 0;
      ifc.mem_ready = 1'b0;
      ifc.mem_rdata = 32'h0;
      forever begin
         @(posedge nub_clkn);
         #1;
         if (ifc.mem_ready) begin
            ifc.mem_ready = 1'b0;
            wcnt          = 0;
         end else if (ifc.mem_valid && ifc.mem_addr[31:28] != 4'hD) begin
            if (wcnt < wait_of(ifc.mem_addr)) begin
               wcnt++;
            end else begin
               mem_model[ifc.mem_addr[11:2]] = merge(mem_model[ifc.mem_addr[11:2]],
                                                     ifc.mem_wdata, ifc.mem_write);
               ifc.mem_rdata = mem_model[ifc.mem_addr[11:2]];
               ifc.mem_ready = 1'b1;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      bit   prev_v;
      gnt_t cur;
      prev_v = 1'b0;
      cur    = '{0, 1'b0, 4'h0, 32'h0, 32'h0};
      forever begin
         @(posedge nub_clkn);
         if (cyc < LOG_N) begin
            busy_log[cyc]  = ifc.arb_busy;
            valid_log[cyc] = ifc.mem_valid;
         end
         if (ifc.mem_valid && !prev_v) begin
            cur = '{cyc, ifc.arb_owner, ifc.mem_write, ifc.mem_addr, ifc.mem_wdata};
            obs_g.push_back(cur);
         end else if (ifc.mem_valid && (ifc.mem_addr !== cur.addr ||
                  ifc.mem_wdata !== cur.wd || ifc.mem_write !== cur.wr)) begin
            unstable++;
         end
         if (ifc.a_ready) obs_c.push_back('{cyc, 1'b0, ifc.a_rdata, ifc.a_error});
         if (ifc.b_ready) obs_c.push_back('{cyc, 1'b1, ifc.b_rdata, ifc.b_error});
         prev_v = ifc.mem_valid;
      end
   end

   task automatic set_port(input bit p, input bit v, input req_t r);
      if (p) begin
         ifc.b_valid = v;
         ifc.b_write = v ? r.wr   : 4'h0;
         ifc.b_addr  = v ? r.addr : 32'h0;
         ifc.b_wdata = v ? r.wd   : 32'h0;
         ifc.b_lock  = v & r.lock;
      end else begin
         ifc.a_valid = v;
         ifc.a_write = v ? r.wr   : 4'h0;
         ifc.a_addr  = v ? r.addr : 32'h0;
         ifc.a_wdata = v ? r.wd   : 32'h0;
      end
   endtask

   task automatic drive_port(input bit p);
      int n;
      n = p ? req_b.size() : req_a.size();
      for (int k = 0; k < n; k++) begin
         req_t r;
         int   waited;
         bit   seen;
         r = p ? req_b[k] : req_a[k];
         repeat (r.gap) begin
            @(posedge nub_clkn);
            #1;
         end
         set_port(p, 1'b1, r);
         if (p) iss_b.push_back(cyc + 1);
         else   iss_a.push_back(cyc + 1);
         seen   = 1'b0;
         waited = 0;
         while (!seen && waited < 300) begin
            @(posedge nub_clkn);
            waited++;
            seen = p ? ifc.b_ready : ifc.a_ready;
         end
         check_eq(p ? "b.ready_seen" : "a.ready_seen", 32'(seen), 32'd1);
         #1;
         set_port(p, 1'b0, r);
         @(posedge nub_clkn);
         #1;
      end
   endtask

   task automatic do_reset();
      req_t z;
      z = '{4'h0, 32'h0, 32'h0, 1'b0, 0};
      @(posedge nub_clkn);
      #1;
      set_port(1'b0, 1'b0, z);
      set_port(1'b1, 1'b0, z);
      nub_resetn = 1'b0;
      repeat (2) @(posedge nub_clkn);
      #1;
      nub_resetn = 1'b1;
   endtask

   // Schedule model: every grant happens at the first IDLE edge a request is visible,
   // lasts min(wait+1, timeout) edges, and arbitration resumes two edges later.
   task automatic model_check(input string tag, input int s0, input int s1);
      int          ia, ib, t, c, gi, ci, mb, mv, ea, eb;
      bit          last, lock, p, ok_a, ok_b, hang, seen_a;
      req_t        r;
      logic [31:0] exp_rd, last_a_rd;
      ia = 0; ib = 0; t = 0; gi = 0; ci = 0;
      last = 1'b1; lock = 1'b0; seen_a = 1'b0; last_a_rd = 32'h0;
      for (int k = 0; k < LOG_N; k++) exp_busy[k] = 1'b0;
      while (1) begin
         ea = (ia < iss_a.size()) ? iss_a[ia] : INF;
         eb = (ib < iss_b.size()) ? iss_b[ib] : INF;
         if (LOCK_EN && lock) begin
            if (eb == INF) break;
            t = (t > eb) ? t : eb;
            p = 1'b1;
         end else begin
            if (ea == INF && eb == INF) break;
            t    = (t > ((ea < eb) ? ea : eb)) ? t : ((ea < eb) ? ea : eb);
            ok_a = (ea <= t);
            ok_b = (eb <= t);
            p    = (ok_a && ok_b) ? ~last : ok_b;
         end
         r    = p ? req_b[ib] : req_a[ia];
         hang = (r.addr[31:28] == 4'hD);
         c    = t + (hang ? TB_TO : wait_of(r.addr) + 1);
         if (hang) begin
            exp_rd = 32'hFFFF_FFFF;
         end else begin
            ref_mem[r.addr[11:2]] = merge(ref_mem[r.addr[11:2]], r.wd, r.wr);
            exp_rd = ref_mem[r.addr[11:2]];
         end
         if (gi < obs_g.size()) begin
            check_eq($sformatf("%s.g%0d.edge", tag, gi), obs_g[gi].edge_n, t);
            check_eq($sformatf("%s.g%0d.owner", tag, gi), 32'(obs_g[gi].port), 32'(p));
            check_eq($sformatf("%s.g%0d.addr", tag, gi), obs_g[gi].addr, r.addr);
            check_eq($sformatf("%s.g%0d.write", tag, gi), 32'(obs_g[gi].wr), 32'(r.wr));
            check_eq($sformatf("%s.g%0d.wdata", tag, gi), obs_g[gi].wd, r.wd);
         end
         if (ci < obs_c.size()) begin
            check_eq($sformatf("%s.c%0d.edge", tag, ci), obs_c[ci].edge_n, c);
            check_eq($sformatf("%s.c%0d.port", tag, ci), 32'(obs_c[ci].port), 32'(p));
            check_eq($sformatf("%s.c%0d.rdata", tag, ci), obs_c[ci].rdata, exp_rd);
            check_eq($sformatf("%s.c%0d.err", tag, ci), 32'(obs_c[ci].err), 32'(hang));
         end
         gi++;
         ci++;
         for (int k = t; k < c && k < LOG_N; k++) exp_busy[k] = 1'b1;
         if (!p) begin
            seen_a    = 1'b1;
            last_a_rd = exp_rd;
         end
         if (p) lock = hang ? 1'b0 : r.lock;
         last = p;
         if (p) ib++;
         else   ia++;
         t = c + 2;
      end
      check_eq({tag, ".n_grants"}, obs_g.size(), gi);
      check_eq({tag, ".n_completions"}, obs_c.size(), ci);
      check_eq({tag, ".mem_stable"}, unstable, 0);
      mb = 0;
      mv = 0;
      for (int k = s0 + 1; k <= s1 && k < LOG_N; k++) begin
         if (busy_log[k]  != exp_busy[k]) mb++;
         if (valid_log[k] != exp_busy[k]) mv++;
      end
      check_eq({tag, ".busy_trace"}, mb, 0);
      check_eq({tag, ".valid_trace"}, mv, 0);
      if (seen_a) check_eq({tag, ".a_rdata_hold"}, ifc.a_rdata, last_a_rd);
   endtask

   task automatic run_scn(input string tag);
      int s0;
      do_reset();
      obs_g.delete();
      obs_c.delete();
      iss_a.delete();
      iss_b.delete();
      unstable = 0;
      s0 = cyc;
      fork
         drive_port(1'b0);
         drive_port(1'b1);
      join
      repeat (4) @(posedge nub_clkn);
      #1;
      model_check(tag, s0, cyc);
      req_a.delete();
      req_b.delete();
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.wr   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      r.addr = {(($urandom_range(0, 7) == 0) ? 4'hD : 4'h1), 20'h0,
                6'($urandom_range(0, 15)), 2'b00};
      r.wd   = $urandom;
      r.lock = 1'($urandom_range(0, 1));
      r.gap  = $urandom_range(0, 3);
      return r;
   endfunction

   initial begin
      int   n;
      bit   seen;
      req_t r;
      for (int i = 0; i < 1024; i++) begin
         mem_model[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
         ref_mem[i]   = mem_model[i];
      end
      r = '{4'h0, 32'h0, 32'h0, 1'b0, 0};
      set_port(1'b0, 1'b0, r);
      set_port(1'b1, 1'b0, r);
      nub_resetn = 1'b1;
      #2;
      nub_resetn = 1'b0;
      @(posedge nub_clkn);
      check_eq("rst.mem_valid", 32'(ifc.mem_valid), 32'd0);
      check_eq("rst.a_ready",   32'(ifc.a_ready),   32'd0);
      check_eq("rst.b_ready",   32'(ifc.b_ready),   32'd0);
      check_eq("rst.a_error",   32'(ifc.a_error),   32'd0);
      check_eq("rst.arb_owner", 32'(ifc.arb_owner), 32'd0);
      check_eq("rst.arb_busy",  32'(ifc.arb_busy),  32'd0);
      check_eq("rst.a_rdata",   ifc.a_rdata,        32'h0);
      check_eq("rst.mem_addr",  ifc.mem_addr,       32'h0);
      #1;
      nub_resetn = 1'b1;

      // Reset while BUSY on a transfer the memory never answers.
      @(posedge nub_clkn);
      #1;
      r = '{4'h0, 32'hD000_0000, 32'h0, 1'b0, 0};
      set_port(1'b0, 1'b1, r);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(posedge nub_clkn);
         n++;
         seen = ifc.mem_valid;
      end
      check_eq("rstb.mv_seen", 32'(seen), 32'd1);
      repeat (2) @(posedge nub_clkn);
      #2;
      nub_resetn = 1'b0;
      #1;
      check_eq("rstb.mem_valid", 32'(ifc.mem_valid), 32'd0);
      check_eq("rstb.arb_busy",  32'(ifc.arb_busy),  32'd0);
      check_eq("rstb.a_ready",   32'(ifc.a_ready),   32'd0);
      set_port(1'b0, 1'b0, r);
      @(posedge nub_clkn);
      #1;
      nub_resetn = 1'b1;

      // Reset landing on a b_ready pulse.
      @(posedge nub_clkn);
      #1;
      r = '{4'h0, 32'h1000_0010, 32'h0, 1'b0, 0};
      set_port(1'b1, 1'b1, r);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(posedge nub_clkn);
         n++;
         seen = ifc.b_ready;
      end
      check_eq("rstr.b_ready_seen", 32'(seen), 32'd1);
      #2;
      nub_resetn = 1'b0;
      #1;
      check_eq("rstr.b_ready", 32'(ifc.b_ready), 32'd0);
      check_eq("rstr.b_rdata", ifc.b_rdata,      32'h0);
      set_port(1'b1, 1'b0, r);
      @(posedge nub_clkn);
      #1;
      nub_resetn = 1'b1;

      for (int k = 0; k < 4; k++) begin
         req_a.push_back('{4'h1 << (k % 4), 32'h1000_0040 + 32'(4 * k), $urandom, 1'b0, 0});
         req_b.push_back('{4'h0, 32'h1000_0080 + 32'(4 * k), 32'h0, 1'b0, 0});
      end
      run_scn("tie");

      req_a.push_back('{4'hF, 32'hF000_0000, 32'h8765_4321, 1'b0, 0});
      req_a.push_back('{4'h0, 32'hF000_0000, 32'h0,         1'b0, 0});
      run_scn("plan");
      check_eq("plan.a_rdata", ifc.a_rdata, 32'h8765_4321);

      req_b.push_back('{4'h0, 32'h1000_0030, 32'h0, 1'b0, 0});
      req_a.push_back('{4'h0, 32'h1000_0034, 32'h0, 1'b0, 2});
      run_scn("midreq");

      req_a.push_back('{4'h0, 32'hD000_0000, 32'h0, 1'b0, 0});
      req_a.push_back('{4'h0, 32'h1000_0020, 32'h0, 1'b0, 0});
      run_scn("timeout");

      for (int k = 0; k < 4; k++) begin
         req_b.push_back('{4'h3, 32'h1000_0000 + 32'(4 * k), $urandom, (k < 3), 0});
      end
      req_a.push_back('{4'h0, 32'h1000_0000, 32'h0, 1'b0, 1});
      run_scn("lock");

      for (int s = 0; s < 6; s++) begin
         int na;
         int nb;
         na = $urandom_range(1, 6);
         nb = $urandom_range(1, 6);
         for (int k = 0; k < na; k++) req_a.push_back(rand_req());
         for (int k = 0; k < nb; k++) begin
            r = rand_req();
            if (k == nb - 1) begin
               r.lock         = 1'b0;
               r.addr[31:28]  = 4'h1;
            end
            req_b.push_back(r);
         end
         run_scn($sformatf("rand%0d", s));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/nubus_mem_arbiter.md
Name: nubus_mem_arbiter

Overview:
- Shares the single slave memory port (mem_valid/mem_ready/mem_write/mem_addr/mem_wdata/mem_rdata) between two requesters.
- Port A is the NuBus slave side of the nubus core; port B is a local agent (DMA/CPU-side logic) on the card.
- Ties are resolved round-robin, one transaction is in flight at a time, and a watchdog terminates transfers that the memory never acknowledges.

Parameters:
- TIMEOUT_CLOCKS, default 255: clocks in BUSY without mem_ready before forced termination; 0 disables the watchdog.
- TIMEOUT_RDATA, default 32'hFFFFFFFF: read data returned on timeout.

Ports:
- nub_clkn  in  1  clock; all registers update on the falling edge of nub_clkn, the same edge the memory uses.
- nub_resetn  in  1  reset; asynchronous, active-low.
- a_valid  in  1  port A request.
- a_write  in  4  port A byte write enables; 0 means read.
- a_addr  in  32  port A address.
- a_wdata  in  32  port A write data.
- a_rdata  out  32  port A read data.
- a_ready  out  1  port A completion pulse.
- a_error  out  1  port A timeout flag, valid with a_ready.
- b_valid, b_write, b_addr, b_wdata, b_rdata, b_ready, b_error: same as port A, for port B.
- b_lock  in  1  port B locked-sequence request (see Optional Feature).
- mem_valid  out  1  memory request.
- mem_write  out  4  memory byte enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory completion.
- arb_owner  out  1  current/last owner: 0 = A, 1 = B.
- arb_busy  out  1  high in BUSY.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner = B, so A wins the first tie; watchdog counter 0.
- States are IDLE, BUSY and RECOVER.
- IDLE:
  - a_valid only -> grant A; b_valid only -> grant B.
  - Both valid -> grant the port that is not last_owner.
  - On grant, the owner's write/addr/wdata are captured into the mem_* registers, mem_valid is set, arb_owner is updated, and the state moves to BUSY.
  - Latency is 1 edge from valid sampled to mem_valid high.
- BUSY:
  - mem_valid is held high and the mem_* outputs are held stable.
  - The watchdog increments every edge.
  - Dropping the owner's valid has no effect; the captured transaction completes.
  - A request from the other port waits; no preemption.
- Completion (mem_ready sampled high in BUSY):
  - The owner's rdata <= mem_rdata, ready pulses high for exactly 1 clock, and error = 0.
  - mem_valid <= 0, last_owner <= owner, and the state moves to RECOVER.
  - Write transactions also update rdata (don't-care to the requester).
- Timeout (counter reaches TIMEOUT_CLOCKS with mem_ready low, TIMEOUT_CLOCKS != 0):
  - Same as completion, but rdata = TIMEOUT_RDATA and error = 1 for the pulse.
  - mem_ready arriving on the same edge as the timeout takes precedence; that is a normal completion.
- RECOVER:
  - Lasts one clock. The requester must drop valid in this cycle.
  - The previous owner's valid is ignored; the other port's valid is ignored too, and arbitration resumes in IDLE next edge.
  - Minimum cost is 3 clocks per transaction plus memory wait states.
- Other rules:
  - mem_ready outside BUSY is ignored.
  - rdata outputs hold their last value until the next completion for that port.
  - Assertion of nub_resetn mid-transaction immediately clears mem_valid and the ready pulses; no completion is reported.

Optional Feature:
- Macro: NUBUS_ARB_LOCK_EN.
- With the macro defined:
  - If b_lock is high at a port-B completion, a lock flag is set.
  - While the flag is set, IDLE grants only B; A waits even if B is idle.
  - The flag clears at a B completion with b_lock low, or on a B timeout.
  - A completion never sets the flag.
- Without the macro: b_lock is ignored, and the flag logic is not synthesized.

Test Plan:
- Single A write: a_write=4'hF, a_addr=32'hF0000000, a_wdata=32'h87654321, memory with 1 wait clock.
  - mem_valid rises 1 edge after a_valid, with the captured values.
  - a_ready is a 1-clock pulse and a_error=0.
  - An A read of the same address returns a_rdata=32'h87654321.
- Simultaneous a_valid and b_valid, both held, 4 transactions each:
  - First grant A, then strict alternation A, B, A, B.
  - arb_owner toggles each grant; no port is served twice in a row.
- B in BUSY, A asserts mid-transaction:
  - B completes unchanged; A is granted 2 edges after b_ready (RECOVER, then IDLE).
  - Max wait is observable on arb_busy.
- Memory never asserts ready, TIMEOUT_CLOCKS=8:
  - Exactly 8 edges after mem_valid rises, the owner's ready and error pulse together.
  - rdata=32'hFFFFFFFF and mem_valid drops.
  - The next request proceeds normally.
- Reset asserted during BUSY:
  - mem_valid, a_ready and b_ready go to 0 asynchronously.
  - After release, a tie grants A first.
- NUBUS_ARB_LOCK_EN defined, with b_lock=1 over 3 B transactions and a_valid held:
  - A is blocked until the B completion with b_lock=0, and is then granted.
  - With the macro undefined, A and B alternate instead.
